// File: rtl/forward_hazard_unit_pkg.sv
// Shared encodings for the operand forwarding / load-use hazard unit.
// Result-source selectors and hazard FSM states.
package forward_hazard_unit_pkg;

  typedef enum logic [1:0] {
    RD_ALU = 2'd0,
    RD_MEM = 2'd1,
    RD_PC  = 2'd2,
    RD_CMP = 2'd3
  } regdst_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } fsm_e;

endpackage

// File: rtl/forward_hazard_unit_fwd_port_mux.sv
// Per-operand forwarding select: youngest matching producer wins,
// x0 always reads as zero, a stage-1 load feeding a used operand flags a hazard.
module fwd_port_mux
  import forward_hazard_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 2
) (
  input  logic [4:0]                 rs,
  input  logic                       used,
  input  logic [XLEN-1:0]            rdata,
  input  logic [NUM_STAGES-1:0]      stg_vld,
  input  logic [NUM_STAGES-1:0]      stg_regwr,
  input  logic [NUM_STAGES*2-1:0]    stg_regdst,
  input  logic [NUM_STAGES*5-1:0]    stg_rd,
  input  logic [NUM_STAGES*2-1:0]    stg_cmp,
  input  logic [NUM_STAGES*XLEN-1:0] stg_alu,
  input  logic [NUM_STAGES*XLEN-1:0] stg_mem,
  input  logic [NUM_STAGES*XLEN-1:0] stg_link,
  output logic [XLEN-1:0]            data,
  output logic                       hit,
  output logic                       haz
);

  // Walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    data = rdata;
    hit  = 1'b0;
    haz  = 1'b0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if (stg_vld[s] && stg_regwr[s] &&
          stg_rd[s*5 +: 5] == rs && rs != 5'd0) begin
        hit = 1'b1;
        haz = 1'b0;
        unique case (regdst_e'(stg_regdst[s*2 +: 2]))
          RD_ALU: data = stg_alu[s*XLEN +: XLEN];
          RD_MEM: begin
            data = stg_mem[s*XLEN +: XLEN];
            haz  = (s == 0) && used;
          end
          RD_PC:  data = stg_link[s*XLEN +: XLEN];
          RD_CMP: data = XLEN'(stg_cmp[s*2 +: 2]);
        endcase
      end
    end
    if (rs == 5'd0) data = '0;
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and load-use stall control for the EX stage.
// Optional perf counters perf_fwd/perf_stall under FWD_PERF_CNT_EN.
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 2,
  parameter int NUM_STAGES = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_SRC*5-1:0]       src_rs,
  input  logic [NUM_SRC-1:0]         src_used,
  input  logic [NUM_SRC*XLEN-1:0]    src_rdata,
  input  logic [NUM_STAGES-1:0]      stg_vld,
  input  logic [NUM_STAGES-1:0]      stg_regwr,
  input  logic [NUM_STAGES*2-1:0]    stg_regdst,
  input  logic [NUM_STAGES*5-1:0]    stg_rd,
  input  logic [NUM_STAGES*2-1:0]    stg_cmp,
  input  logic [NUM_STAGES*XLEN-1:0] stg_alu,
  input  logic [NUM_STAGES*XLEN-1:0] stg_mem,
  input  logic [NUM_STAGES*XLEN-1:0] stg_link,
  output logic [NUM_SRC*XLEN-1:0]    fwd_data,
  output logic [NUM_SRC-1:0]         fwd_hit,
  output logic                       stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]                perf_fwd,
  output logic [31:0]                perf_stall
`endif
);

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);
  localparam bit         MULTI    = (LOAD_LAT > 1);

  logic [NUM_SRC*XLEN-1:0] mux_data;
  logic [NUM_SRC-1:0]      mux_hit;
  logic [NUM_SRC-1:0]      haz;
  logic [NUM_SRC*XLEN-1:0] fwd_data_d, fwd_data_q;
  logic [NUM_SRC-1:0]      fwd_hit_d, fwd_hit_q;
  fsm_e                    state_d, state_q;
  logic [1:0]              stall_cnt_d, stall_cnt_q;
  logic                    stall_c;
  logic                    upd;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
    fwd_port_mux #(
      .XLEN       (XLEN),
      .NUM_STAGES (NUM_STAGES)
    ) u_mux (
      .rs         (src_rs[i*5 +: 5]),
      .used       (src_used[i]),
      .rdata      (src_rdata[i*XLEN +: XLEN]),
      .stg_vld    (stg_vld),
      .stg_regwr  (stg_regwr),
      .stg_regdst (stg_regdst),
      .stg_rd     (stg_rd),
      .stg_cmp    (stg_cmp),
      .stg_alu    (stg_alu),
      .stg_mem    (stg_mem),
      .stg_link   (stg_link),
      .data       (mux_data[i*XLEN +: XLEN]),
      .hit        (mux_hit[i]),
      .haz        (haz[i])
    );
  end

  // The counter reaching zero ends the stall, giving LOAD_LAT stall cycles.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    stall_c     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && |haz) begin
          stall_c     = 1'b1;
          stall_cnt_d = CNT_INIT;
          if (MULTI) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        stall_c = 1'b1;
        if (en) begin
          if (stall_cnt_q <= 2'd1) begin
            stall_cnt_d = 2'd0;
            state_d     = ST_IDLE;
          end else begin
            stall_cnt_d = stall_cnt_q - 2'd1;
          end
        end
      end
    endcase
    if (rst) stall_c = 1'b0;
  end

  assign upd = en && !stall_c;

  always_comb begin
    fwd_data_d = fwd_data_q;
    fwd_hit_d  = fwd_hit_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (upd && !haz[i]) begin
        fwd_data_d[i*XLEN +: XLEN] = mux_data[i*XLEN +: XLEN];
        fwd_hit_d[i]               = mux_hit[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_data_q  <= '0;
      fwd_hit_q   <= '0;
      state_q     <= ST_IDLE;
      stall_cnt_q <= 2'd0;
    end else begin
      fwd_data_q  <= fwd_data_d;
      fwd_hit_q   <= fwd_hit_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_data = fwd_data_q;
  assign fwd_hit  = fwd_hit_q;
  assign stall    = stall_c;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_fwd_d, perf_fwd_q;
  logic [31:0] perf_stall_d, perf_stall_q;

  always_comb begin
    perf_fwd_d   = perf_fwd_q;
    perf_stall_d = perf_stall_q;
    if (upd && |(mux_hit & ~haz)) perf_fwd_d = perf_fwd_q + 32'd1;
    if (en && stall_c) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fwd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fwd_q   <= perf_fwd_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fwd   = perf_fwd_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit (LOAD_LAT=2 build).
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_forward_hazard_unit;

  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int NST  = 2;
  localparam int LL   = 2;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic [4:0]  rs    [NS];
  logic        used  [NS];
  logic [31:0] rdata [NS];
  logic        vld   [NST];
  logic        regwr [NST];
  logic [1:0]  dst   [NST];
  logic [4:0]  rd    [NST];
  logic [1:0]  cmp   [NST];
  logic [31:0] alu   [NST];
  logic [31:0] mem   [NST];
  logic [31:0] link  [NST];

  logic [NS*5-1:0]     src_rs;
  logic [NS-1:0]       src_used;
  logic [NS*XLEN-1:0]  src_rdata;
  logic [NST-1:0]      stg_vld, stg_regwr;
  logic [NST*2-1:0]    stg_regdst, stg_cmp;
  logic [NST*5-1:0]    stg_rd;
  logic [NST*XLEN-1:0] stg_alu, stg_mem, stg_link;
  logic [NS*XLEN-1:0]  fwd_data;
  logic [NS-1:0]       fwd_hit;
  logic                stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] perf_fwd, perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  // model state
  int          remaining;
  logic [31:0] exp_data [NS];
  logic        exp_hit  [NS];

  always #5 clk = ~clk;

  always_comb begin
    src_rs = '0; src_used = '0; src_rdata = '0;
    stg_vld = '0; stg_regwr = '0; stg_regdst = '0;
    stg_cmp = '0; stg_rd = '0;
    stg_alu = '0; stg_mem = '0; stg_link = '0;
    for (int i = 0; i < NS; i++) begin
      src_rs[i*5 +: 5]         = rs[i];
      src_used[i]              = used[i];
      src_rdata[i*XLEN +: XLEN] = rdata[i];
    end
    for (int s = 0; s < NST; s++) begin
      stg_vld[s]              = vld[s];
      stg_regwr[s]            = regwr[s];
      stg_regdst[s*2 +: 2]    = dst[s];
      stg_cmp[s*2 +: 2]       = cmp[s];
      stg_rd[s*5 +: 5]        = rd[s];
      stg_alu[s*XLEN +: XLEN]  = alu[s];
      stg_mem[s*XLEN +: XLEN]  = mem[s];
      stg_link[s*XLEN +: XLEN] = link[s];
    end
  end

  forward_hazard_unit #(
    .XLEN(XLEN), .NUM_SRC(NS), .NUM_STAGES(NST), .LOAD_LAT(LL)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .src_rs(src_rs), .src_used(src_used), .src_rdata(src_rdata),
    .stg_vld(stg_vld), .stg_regwr(stg_regwr),
    .stg_regdst(stg_regdst), .stg_rd(stg_rd), .stg_cmp(stg_cmp),
    .stg_alu(stg_alu), .stg_mem(stg_mem), .stg_link(stg_link),
    .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall(stall)
`ifdef FWD_PERF_CNT_EN
    , .perf_fwd(perf_fwd), .perf_stall(perf_stall)
`endif
  );

  // {haz, hit, data}: first (youngest) matching writer decides
  function automatic logic [33:0] ref_port(int i);
    if (rs[i] == 5'd0) return 34'd0;
    for (int s = 0; s < NST; s++) begin
      if (vld[s] && regwr[s] && rd[s] == rs[i]) begin
        case (dst[s])
          2'd0: return {2'b01, alu[s]};
          2'd1: return {(s == 0) && used[i], 1'b1, mem[s]};
          2'd2: return {2'b01, link[s]};
          default: return {2'b01, 30'd0, cmp[s]};
        endcase
      end
    end
    return {2'b00, rdata[i]};
  endfunction

  function automatic logic any_haz();
    logic h;
    h = 1'b0;
    for (int i = 0; i < NS; i++) h = h | ref_port(i)[33];
    return h;
  endfunction

  function automatic logic model_stall();
    return !rst && (remaining > 0 || (en && any_haz()));
  endfunction

  task automatic model_reset();
    remaining = 0;
    for (int i = 0; i < NS; i++) begin
      exp_data[i] = '0;
      exp_hit[i]  = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NS; i++) begin
      rs[i] = '0; used[i] = 1'b0; rdata[i] = '0;
    end
    for (int s = 0; s < NST; s++) begin
      vld[s] = 1'b0; regwr[s] = 1'b0; dst[s] = '0; rd[s] = '0;
      cmp[s] = '0; alu[s] = '0; mem[s] = '0; link[s] = '0;
    end
  endtask

  task automatic set_stage(int s, logic [1:0] d, logic [4:0] r,
                           logic [31:0] v);
    vld[s] = 1'b1; regwr[s] = 1'b1; dst[s] = d; rd[s] = r;
    alu[s] = v; mem[s] = v; link[s] = v; cmp[s] = v[1:0];
  endtask

  // advance one edge and update the model from pre-edge inputs
  task automatic tick();
    logic [33:0] r [NS];
    logic        st, ah;
    st = model_stall();
    ah = any_haz();
    for (int i = 0; i < NS; i++) r[i] = ref_port(i);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (en) begin
      if (remaining > 0) remaining--;
      else if (ah) remaining = LL - 1;
      if (!st) begin
        for (int i = 0; i < NS; i++) begin
          if (!r[i][33]) begin
            exp_data[i] = r[i][31:0];
            exp_hit[i]  = r[i][32];
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    en = 1'b1;
    set_stage(0, 2'd1, 5'd7, 32'h1);
    rs[0] = 5'd7; used[0] = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%0b want=0", stall);
    end
    checks++;
    if (fwd_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", fwd_data);
    end
    checks++;
    if (fwd_hit !== '0) begin
      failures++;
      $display("FAIL reset_hit got=%b want=0", fwd_hit);
    end
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_priority();
    clear_inputs();
    en = 1'b1;
    set_stage(0, 2'd0, 5'd5, 32'h11);
    set_stage(1, 2'd0, 5'd5, 32'h22);
    rs[0] = 5'd5; used[0] = 1'b1; rdata[0] = 32'h99;
    rdata[1] = 32'h77;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL prio_stall got=%0b want=0", stall);
    end
    tick();
    checks++;
    if (fwd_data[31:0] !== 32'h11 || fwd_hit[0] !== 1'b1) begin
      failures++;
      $display("FAIL prio_port0 got=%h/%b want=11/1",
               fwd_data[31:0], fwd_hit[0]);
    end
    checks++;
    if (fwd_data[63:32] !== 32'h0 || fwd_hit[1] !== 1'b0) begin
      failures++;
      $display("FAIL prio_port1_x0 got=%h/%b want=0/0",
               fwd_data[63:32], fwd_hit[1]);
    end
  endtask

  task automatic test_mem_forward();
    clear_inputs();
    en = 1'b1;
    set_stage(0, 2'd0, 5'd9, 32'h5);
    set_stage(1, 2'd1, 5'd7, 32'hDEAD);
    rs[1] = 5'd7; used[1] = 1'b1; rdata[1] = 32'hBAD;
    rs[0] = 5'd4; rdata[0] = 32'h44;
    tick();
    checks++;
    if (fwd_data[63:32] !== 32'hDEAD || fwd_hit[1] !== 1'b1) begin
      failures++;
      $display("FAIL mem2_fwd got=%h/%b want=dead/1",
               fwd_data[63:32], fwd_hit[1]);
    end
    checks++;
    if (fwd_data[31:0] !== 32'h44 || fwd_hit[0] !== 1'b0) begin
      failures++;
      $display("FAIL rf_read got=%h/%b want=44/0",
               fwd_data[31:0], fwd_hit[0]);
    end
  endtask

  task automatic test_load_use();
    int n;
    clear_inputs();
    en = 1'b1;
    set_stage(0, 2'd1, 5'd7, 32'h1234);
    rs[1] = 5'd7; used[1] = 1'b1;
    n = 0;
    #1;
    if (stall === 1'b1) n++;
    tick();
    // load advanced to stage 2, bubble in stage 1
    vld[0] = 1'b0;
    set_stage(1, 2'd1, 5'd7, 32'hBEEF);
    #1;
    if (stall === 1'b1) n++;
    checks++;
    if (fwd_data[63:32] !== 32'hDEAD) begin
      failures++;
      $display("FAIL lu_hold got=%h want=dead", fwd_data[63:32]);
    end
    tick();
    if (stall === 1'b1) n++;
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL lu_len got=%0d want=2", n);
    end
    tick();
    checks++;
    if (fwd_data[63:32] !== 32'hBEEF || fwd_hit[1] !== 1'b1) begin
      failures++;
      $display("FAIL lu_after got=%h/%b want=beef/1",
               fwd_data[63:32], fwd_hit[1]);
    end
  endtask

  task automatic test_x0();
    clear_inputs();
    en = 1'b1;
    set_stage(0, 2'd0, 5'd0, 32'h55);
    rs[0] = 5'd0; used[0] = 1'b1; rdata[0] = 32'h77;
    tick();
    checks++;
    if (fwd_data[31:0] !== 32'h0 || fwd_hit[0] !== 1'b0) begin
      failures++;
      $display("FAIL x0 got=%h/%b want=0/0",
               fwd_data[31:0], fwd_hit[0]);
    end
  endtask

  task automatic test_cmp_pc();
    clear_inputs();
    en = 1'b1;
    set_stage(0, 2'd3, 5'd3, 32'hFFFF_FFFE);
    set_stage(1, 2'd2, 5'd31, 32'h104);
    rs[0] = 5'd3; used[0] = 1'b1;
    rs[1] = 5'd31; used[1] = 1'b1;
    tick();
    checks++;
    if (fwd_data[31:0] !== 32'h2 || fwd_hit[0] !== 1'b1) begin
      failures++;
      $display("FAIL cmp got=%h/%b want=2/1",
               fwd_data[31:0], fwd_hit[0]);
    end
    checks++;
    if (fwd_data[63:32] !== 32'h104 || fwd_hit[1] !== 1'b1) begin
      failures++;
      $display("FAIL link got=%h/%b want=104/1",
               fwd_data[63:32], fwd_hit[1]);
    end
  endtask

  task automatic test_freeze();
    int n;
    clear_inputs();
    en = 1'b1;
    set_stage(0, 2'd1, 5'd7, 32'h1);
    rs[1] = 5'd7; used[1] = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      en = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
      #1;
      if (stall !== 1'b1) break;
      n++;
      tick();
      vld[0] = 1'b0;
    end
    en = 1'b1;
    checks++;
    if (n !== 5) begin
      failures++;
      $display("FAIL freeze_len got=%0d want=5", n);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seen;
    clear_inputs();
    en = 1'b1;
    set_stage(0, 2'd1, 5'd6, 32'h1);
    rs[0] = 5'd6; used[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      seen[k] = stall;
      tick();
    end
    checks++;
    if (seen !== 3'b111) begin
      failures++;
      $display("FAIL b2b_restart got=%b want=111", seen);
    end
    vld[0] = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL b2b_hold got=%0b want=1", stall);
    end
    tick();
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL b2b_release got=%0b want=0", stall);
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    en = 1'b1;
    set_stage(0, 2'd0, 5'd8, 32'h88);
    rs[0] = 5'd8; used[0] = 1'b1;
    tick();
    set_stage(0, 2'd1, 5'd8, 32'h1);
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_stall got=%0b want=0", stall);
    end
    checks++;
    if (fwd_data !== '0 || fwd_hit !== '0) begin
      failures++;
      $display("FAIL rst_mid_out got=%h/%b want=0/0",
               fwd_data, fwd_hit);
    end
    clear_inputs();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_release got=%0b want=0", stall);
    end
  endtask

  task automatic test_random();
    logic st;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < NS; i++) begin
        rs[i]    = 5'($urandom_range(0, 3));
        used[i]  = ($urandom_range(0, 3) != 0);
        rdata[i] = $urandom;
      end
      for (int s = 0; s < NST; s++) begin
        vld[s]   = ($urandom_range(0, 3) != 0);
        regwr[s] = ($urandom_range(0, 3) != 0);
        dst[s]   = 2'($urandom_range(0, 3));
        rd[s]    = 5'($urandom_range(0, 3));
        cmp[s]   = 2'($urandom_range(0, 3));
        alu[s]   = $urandom;
        mem[s]   = $urandom;
        link[s]  = $urandom;
      end
      #1;
      st = model_stall();
      checks++;
      if (stall !== st) begin
        failures++;
        $display("FAIL rnd_stall c=%0d got=%0b want=%0b", c, stall, st);
      end
      tick();
      for (int i = 0; i < NS; i++) begin
        checks++;
        if (fwd_data[i*XLEN +: XLEN] !== exp_data[i] ||
            fwd_hit[i] !== exp_hit[i]) begin
          failures++;
          $display("FAIL rnd_port%0d c=%0d got=%h/%b want=%h/%b",
                   i, c, fwd_data[i*XLEN +: XLEN], fwd_hit[i],
                   exp_data[i], exp_hit[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_priority();
    test_mem_forward();
    test_load_use();
    test_x0();
    test_cmp_pc();
    test_freeze();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
